// File: rtl/mem_line_fetch.sv
// Backing-store word memory for the direct-mapped cache. Returns the aligned 4-word line
// holding a requested address a fixed LATENCY cycles after a valid/ready request is accepted.
module mem_line_fetch #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  output logic                resp_valid,
  output logic [ADDR_W-1:0]   resp_addr,
  output logic [4*DATA_W-1:0] line_data,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [15:0]         fetch_count
);

  localparam int                CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_resp_addr;
  logic [4*DATA_W-1:0] r_line_data;
  logic [15:0]         r_fetch_count;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];
  logic                w_accept;
  logic                w_capture;

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_capture = (r_state == WAIT) && (r_wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_next_state = WAIT;
      WAIT:    if (r_wait_cnt == '0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Masking instead of slicing keeps the base a full-width address, so the four
  // word indices below are formed by OR and can never carry past the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_base        <= '0;
      r_resp_addr   <= '0;
      r_line_data   <= '0;
      r_fetch_count <= '0;
    end else begin
      if (w_accept) begin
        r_base     <= req_addr & LINE_MASK;
        r_wait_cnt <= CNT_LOAD;
      end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
      end
      // NOTE: non-blocking reads here see the array before any same-edge write lands,
      // which is what makes a write in the capture cycle invisible to this response.
      if (w_capture) begin
        r_resp_addr <= r_base;
        for (int k = 0; k < 4; k++) begin
          r_line_data[k*DATA_W +: DATA_W] <= r_mem[r_base | ADDR_W'(k)];
        end
      end
      if ((r_state == RESP) && (r_fetch_count != 16'hFFFF)) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end
    end
  end

  // NOTE: the array itself is never reset (that would be a huge reset fan-out);
  // reset only suppresses a write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign req_ready   = (r_state == IDLE);
  assign resp_valid  = (r_state == RESP);
  assign resp_addr   = r_resp_addr;
  assign line_data   = r_line_data;
  assign fetch_count = r_fetch_count;

endmodule

// File: doc/mem_line_fetch.md
Name: mem_line_fetch

Overview:
- Backing-store main memory for the direct-mapped cache. On a miss, the cache requests a 15-bit address; this block returns the aligned 4-word line the cache writes into its data array.
- Models fixed multi-cycle memory latency with a valid/ready request handshake and a single-cycle response pulse.
- Includes a single-word write port for bench preload and a saturating fetch counter for statistics.

Parameters:
- ADDR_W, 15, word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, word width.
- LATENCY, 4, wait cycles between request acceptance and data capture; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request present.
- req_addr  input  ADDR_W  word address of the missing word; low 2 bits are ignored for line selection.
- req_ready  output  1  block can accept a request.
- resp_valid  output  1  one-cycle pulse: line_data and resp_addr are valid.
- resp_addr  output  ADDR_W  line base of the returned line: {req_addr[ADDR_W-1:2], 2'b00}.
- line_data  output  4*DATA_W  word k of the line on bits [DATA_W*k+DATA_W-1 : DATA_W*k].
- wr_en  input  1  single-word write strobe.
- wr_addr  input  ADDR_W  write word address.
- wr_data  input  DATA_W  write data.
- fetch_count  output  16  number of completed fetches; saturates at 16'hFFFF.

Behaviour:
- All state changes on posedge clk. rst is sampled synchronously and overrides every other input, including wr_en.
- Reset values:
  - state = IDLE, req_ready = 1, resp_valid = 0.
  - resp_addr = 0, line_data = 0, fetch_count = 0.
  - The memory array is not cleared by rst.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. If req_valid is high in cycle T, latch line base = {req_addr[ADDR_W-1:2], 2'b00}, load the wait counter with LATENCY-1, and go to WAIT.
  - WAIT: req_ready = 0 and req_valid is ignored. The counter decrements each cycle, so WAIT occupies cycles T+1 .. T+LATENCY.
    - In the last WAIT cycle (counter == 0), words base+0 .. base+3 are read and registered into line_data. Next state is RESP.
  - RESP: resp_valid = 1 for exactly one cycle, T+LATENCY+1, with req_ready = 0. fetch_count increments at the end of this cycle unless it is already 16'hFFFF. Next state is IDLE.
  - Earliest next acceptance is cycle T+LATENCY+2.
- Output hold rules:
  - line_data and resp_addr hold their values after RESP until the next capture.
  - line_data is not modified during WAIT.
- Write port:
  - When wr_en is high, mem[wr_addr] <= wr_data at the clock edge. Writes are accepted in any state.
  - Read/write ordering is read-before-write. A write in the capture cycle (T+LATENCY) to a word of the line being fetched is not visible in that response. A write in cycle T+LATENCY-1 or earlier is visible.
- Line alignment: the line never crosses a 4-word boundary. The top line (base 0x7FFC) returns words 0x7FFC .. 0x7FFF with no wrap-around to address 0.
- Mid-operation reset: rst asserted in WAIT or RESP aborts the fetch. The FSM returns to IDLE with no resp_valid pulse, and fetch_count is cleared. Writes issued in the reset cycle are dropped.
- Invariants:
  - resp_valid and req_ready are never high together.
  - resp_valid is never high for two consecutive cycles.

Test Plan:
- Reset: assert rst for 2 cycles with req_valid = 1 -> req_ready = 1, resp_valid = 0, line_data = 0, fetch_count = 0, and no request is latched.
- Basic fetch (LATENCY = 4): preload mem[0x0124..0x0127] = 0xA0, 0xA1, 0xA2, 0xA3. Request 0x0126 accepted in cycle 10 -> resp_valid only in cycle 15, resp_addr = 0x0124, words 0..3 = 0xA0..0xA3, fetch_count = 1, req_ready high again in cycle 16.
- Back-to-back requests: hold req_valid high continuously with 0x0010 then 0x7FFF -> two responses 6 cycles apart. The second response has resp_addr = 0x7FFC with words 0x7FFC..0x7FFF (no wrap), and fetch_count = 2.
- Write/capture race: fetch 0x0040 accepted at cycle T, write mem[0x0041] = 0x55 in cycle T+3 and mem[0x0042] = 0x66 in cycle T+4 -> word1 = 0x55 and word2 = the old value. A refetch returns word2 = 0x66.
- Reset mid-fetch: rst asserted in cycle T+2 of a fetch -> no resp_valid pulse, fetch_count = 0, and the next request completes normally with correct data.
- Saturation and edge parameter: force 65535 fetches, then one more -> fetch_count stays 0xFFFF. With LATENCY = 1, a request accepted at cycle T -> resp_valid in cycle T+2.
